preproc_frame2lenet: RTL and testbench

PREPROC_FRAME2LENET -- requirements
Module: preproc_frame2lenet

---
 rtl/preproc_frame2lenet.sv | 160 ++++++++++++++++
 tb/tb_preproc_frame2lenet.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/preproc_frame2lenet.sv
// Quantizer-to-LeNet frame preprocessor: buffers pixel beats with frame markers,
// checks line/frame geometry and replays each buffered frame behind a start pulse.
module preproc_frame2lenet #(
    parameter int PIX_BITS   = 8,
    parameter int IMG_W      = 32,
    parameter int IMG_H      = 32,
    parameter int FIFO_DEPTH = 64
) (
    input  logic                          clk,
    input  logic                          arst_n,
    input  logic                          q_valid,
    input  logic                          q_line_last,
    input  logic                          q_frame_last,
    input  logic [7:0]                    q_pixel,
    output logic                          q_ready,
    output logic                          lenet_start,
    output logic                          lenet_v,
    input  logic                          lenet_ready,
    output logic                          lenet_last,
    output logic [PIX_BITS-1:0]           lenet_pix,
    output logic                          err_geom,
    output logic [15:0]                   frame_cnt,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [AW:0]   DEPTH_L = (AW+1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);

    typedef enum logic [1:0] {IDLE, START, STREAM} state_t;
    state_t state, state_nx;

    logic rst_meta, rst_n;
    logic [9:0] mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic empty, full, push, pop, inc_frame;
    logic [7:0] head_pix;
    logic head_sof, head_eof;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic sof_pend, line_end, frame_end;
    logic [PIX_BITS-1:0] cast_pix;

    // Assert asynchronously, release only after two clk edges.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            rst_meta <= 1'b0;
            rst_n    <= 1'b0;
        end else begin
            rst_meta <= 1'b1;
            rst_n    <= rst_meta;
        end
    end

    assign fifo_level = wr_ptr - rd_ptr;
    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (fifo_level == DEPTH_L);
    assign q_ready    = rst_n && !full;
    assign push       = q_valid && q_ready;
    assign {head_pix, head_sof, head_eof} = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= {q_pixel, sof_pend, q_frame_last};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            state     <= IDLE;
            frame_cnt <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            state <= state_nx;
            if (inc_frame)
                frame_cnt <= frame_cnt + 16'd1;
        end
    end

    assign line_end  = (col == COL_MAX);
    assign frame_end = line_end && (row == ROW_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col      <= '0;
            row      <= '0;
            sof_pend <= 1'b1;
            err_geom <= 1'b0;
        end else if (push) begin
            if ((q_line_last != line_end) || (q_frame_last != frame_end))
                err_geom <= 1'b1;
            sof_pend <= q_frame_last;
            if (q_frame_last) begin
                col <= '0;
                row <= '0;
            end else if (q_line_last) begin
                col <= '0;
                row <= (row == ROW_MAX) ? '0 : row + 1'b1;
            end else begin
                col <= line_end ? '0 : col + 1'b1;
            end
        end
    end

    always_comb begin
        state_nx    = state;
        pop         = 1'b0;
        inc_frame   = 1'b0;
        lenet_start = 1'b0;
        lenet_v     = 1'b0;
        case (state)
            IDLE: begin
                // A head without sof is a fragment of a frame we never started: drop it.
                if (!empty) begin
                    if (head_sof) state_nx = START;
                    else          pop      = 1'b1;
                end
            end
            START: begin
                lenet_start = 1'b1;
                state_nx    = STREAM;
            end
            STREAM: begin
                lenet_v = !empty;
                if (lenet_v && lenet_ready) begin
                    pop = 1'b1;
                    if (head_eof) begin
                        state_nx  = IDLE;
                        inc_frame = 1'b1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    generate
        if (PIX_BITS == 8) begin : gen_pass
            assign cast_pix = head_pix;
        end else if (PIX_BITS > 8) begin : gen_wide
            assign cast_pix = {{(PIX_BITS-8){head_pix[7]}}, head_pix};
        end else begin : gen_narrow
            localparam logic signed [8:0] HALF = 9'(1 << (7 - PIX_BITS));
            localparam logic signed [8:0] MAXV = 9'((1 << (PIX_BITS - 1)) - 1);
            logic signed [8:0] sum_r, shr;
            assign sum_r    = $signed({head_pix[7], head_pix}) + HALF;
            assign shr      = sum_r >>> (8 - PIX_BITS);
            assign cast_pix = (shr > MAXV) ? MAXV[PIX_BITS-1:0] : shr[PIX_BITS-1:0];
        end
    endgenerate

    assign lenet_pix  = lenet_v ? cast_pix : '0;
    assign lenet_last = lenet_v && head_eof;
endmodule

// File: tb/tb_preproc_frame2lenet.sv
// Randomised bench for preproc_frame2lenet: three pixel widths share one stimulus
// stream and are checked every cycle against a queue-based frame model.
module tb_preproc_frame2lenet;
    localparam int W = 4;
    localparam int H = 4;
    localparam int D = 8;

    logic clk = 1'b0;
    logic arst_n = 1'b1;
    logic q_valid = 1'b0, q_line_last = 1'b0, q_frame_last = 1'b0, lenet_ready = 1'b0;
    logic [7:0] q_pixel = 8'h00;

    logic rdy_a [3];
    logic start_a [3];
    logic v_a [3];
    logic last_a [3];
    logic err_a [3];
    logic [15:0] fcnt_a [3];
    logic [3:0] lvl_a [3];
    logic [7:0]  pix8;
    logic [11:0] pix12;
    logic [3:0]  pix4;

    always #5 clk = ~clk;

    preproc_frame2lenet #(.PIX_BITS(8), .IMG_W(W), .IMG_H(H), .FIFO_DEPTH(D)) dut (
        .clk(clk), .arst_n(arst_n), .q_valid(q_valid), .q_line_last(q_line_last),
        .q_frame_last(q_frame_last), .q_pixel(q_pixel), .q_ready(rdy_a[0]),
        .lenet_start(start_a[0]), .lenet_v(v_a[0]), .lenet_ready(lenet_ready),
        .lenet_last(last_a[0]), .lenet_pix(pix8), .err_geom(err_a[0]),
        .frame_cnt(fcnt_a[0]), .fifo_level(lvl_a[0]));

    preproc_frame2lenet #(.PIX_BITS(12), .IMG_W(W), .IMG_H(H), .FIFO_DEPTH(D)) dut12 (
        .clk(clk), .arst_n(arst_n), .q_valid(q_valid), .q_line_last(q_line_last),
        .q_frame_last(q_frame_last), .q_pixel(q_pixel), .q_ready(rdy_a[1]),
        .lenet_start(start_a[1]), .lenet_v(v_a[1]), .lenet_ready(lenet_ready),
        .lenet_last(last_a[1]), .lenet_pix(pix12), .err_geom(err_a[1]),
        .frame_cnt(fcnt_a[1]), .fifo_level(lvl_a[1]));

    preproc_frame2lenet #(.PIX_BITS(4), .IMG_W(W), .IMG_H(H), .FIFO_DEPTH(D)) dut4 (
        .clk(clk), .arst_n(arst_n), .q_valid(q_valid), .q_line_last(q_line_last),
        .q_frame_last(q_frame_last), .q_pixel(q_pixel), .q_ready(rdy_a[2]),
        .lenet_start(start_a[2]), .lenet_v(v_a[2]), .lenet_ready(lenet_ready),
        .lenet_last(last_a[2]), .lenet_pix(pix4), .err_geom(err_a[2]),
        .frame_cnt(fcnt_a[2]), .fifo_level(lvl_a[2]));

    typedef struct {logic [7:0] pix; bit sof; bit eof;} ent_t;
    typedef struct {logic [7:0] pix; bit ll; bit fl;} beat_t;
    ent_t  mq[$];
    beat_t sq[$];

    // phase: 0 waiting for a frame, 1 start pulse, 2 streaming
    int phase, sync_cnt, col, row, fcnt;
    bit sof_pend, err;
    int n_chk = 0, n_fail = 0;
    int valid_pct = 100, ready_pct = 100;
    int n_start, n_deliv, n_acc, last_at, cyc;
    int first_acc, first_start, first_v;

    function automatic int cast_val(logic [7:0] p, int bits);
        int sv, v, sh, mx;
        sv = int'($signed(p));
        if (bits >= 8) return sv;
        sh = 8 - bits;
        v  = (sv + (1 << (sh - 1))) >>> sh;
        mx = (1 << (bits - 1)) - 1;
        if (v > mx) v = mx;
        return v;
    endfunction

    task automatic check(string name, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        phase = 0; col = 0; row = 0; fcnt = 0; sof_pend = 1; err = 0; sync_cnt = 0;
    endtask

    task automatic compare_outputs();
        bit e_rdy, e_start, e_v, e_last;
        int e8, e12, e4;
        e_rdy   = (sync_cnt >= 2) && (mq.size() < D);
        e_start = (phase == 1);
        e_v     = (phase == 2) && (mq.size() > 0);
        e_last  = e_v && mq[0].eof;
        e8 = 0; e12 = 0; e4 = 0;
        if (e_v) begin
            e8  = cast_val(mq[0].pix, 8) & 'hFF;
            e12 = cast_val(mq[0].pix, 12) & 'hFFF;
            e4  = cast_val(mq[0].pix, 4) & 'hF;
        end
        for (int i = 0; i < 3; i++) begin
            check($sformatf("q_ready[%0d]", i), int'(rdy_a[i]), int'(e_rdy));
            check($sformatf("lenet_start[%0d]", i), int'(start_a[i]), int'(e_start));
            check($sformatf("lenet_v[%0d]", i), int'(v_a[i]), int'(e_v));
            check($sformatf("lenet_last[%0d]", i), int'(last_a[i]), int'(e_last));
            check($sformatf("err_geom[%0d]", i), int'(err_a[i]), int'(err));
            check($sformatf("frame_cnt[%0d]", i), int'(fcnt_a[i]), fcnt & 'hFFFF);
            check($sformatf("fifo_level[%0d]", i), int'(lvl_a[i]), mq.size());
        end
        check("lenet_pix8", int'(pix8), e8);
        check("lenet_pix12", int'(pix12), e12);
        check("lenet_pix4", int'(pix4), e4);
    endtask

    task automatic step();
        bit acc, le, fe;
        @(negedge clk);
        compare_outputs();
        if (sq.size() > 0 && int'($urandom_range(99)) < valid_pct) begin
            q_valid = 1'b1; q_pixel = sq[0].pix; q_line_last = sq[0].ll; q_frame_last = sq[0].fl;
        end else begin
            q_valid = 1'b0; q_pixel = 8'($urandom);
            q_line_last = 1'($urandom); q_frame_last = 1'($urandom);
        end
        lenet_ready = (int'($urandom_range(99)) < ready_pct);
        acc = 0;
        if (sync_cnt < 2) begin
            sync_cnt++;
        end else begin
            acc = q_valid && (mq.size() < D);
            case (phase)
                0: if (mq.size() > 0) begin
                       if (mq[0].sof) phase = 1;
                       else void'(mq.pop_front());
                   end
                1: phase = 2;
                default: if (mq.size() > 0 && lenet_ready) begin
                       if (mq[0].eof) begin phase = 0; fcnt = (fcnt + 1) & 'hFFFF; end
                       void'(mq.pop_front());
                   end
            endcase
            if (acc) begin
                le = (col == W - 1);
                fe = le && (row == H - 1);
                if (q_line_last != le || q_frame_last != fe) err = 1;
                mq.push_back('{q_pixel, sof_pend, q_frame_last});
                sof_pend = q_frame_last;
                if (q_frame_last) begin col = 0; row = 0; end
                else if (q_line_last) begin col = 0; row = (row + 1) % H; end
                else col = (col + 1) % W;
                void'(sq.pop_front());
            end
        end
        if (acc) begin
            n_acc++;
            if (first_acc < 0) first_acc = cyc;
        end
        if (start_a[0]) begin
            n_start++;
            if (first_start < 0) first_start = cyc;
        end
        if (v_a[0] && first_v < 0) first_v = cyc;
        if (v_a[0] && lenet_ready) begin
            n_deliv++;
            if (last_a[0]) last_at = n_deliv;
        end
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        arst_n = 1'b0;
        q_valid = 1'b0;
        sq.delete();
        model_reset();
        #1;
        check("rst_q_ready", int'(rdy_a[0]), 0);
        check("rst_lenet_v", int'(v_a[0]), 0);
        check("rst_lenet_start", int'(start_a[0]), 0);
        check("rst_lenet_pix", int'(pix8), 0);
        check("rst_lenet_last", int'(last_a[0]), 0);
        check("rst_err_geom", int'(err_a[0]), 0);
        check("rst_frame_cnt", int'(fcnt_a[0]), 0);
        check("rst_fifo_level", int'(lvl_a[0]), 0);
        repeat (2) begin
            @(negedge clk);
            compare_outputs();
        end
        arst_n = 1'b1;
        sync_cnt = 1;
    endtask

    task automatic add_frame(int bad_idx, bit fixed, logic [7:0] p0, logic [7:0] p1, logic [7:0] p2);
        beat_t b;
        for (int i = 0; i < W * H; i++) begin
            b.pix = 8'($urandom);
            if (fixed && i == 0) b.pix = p0;
            if (fixed && i == 1) b.pix = p1;
            if (fixed && i == 2) b.pix = p2;
            b.ll = ((i % W) == W - 1);
            b.fl = (i == W * H - 1);
            if (i == bad_idx) b.ll = !b.ll;
            sq.push_back(b);
        end
    endtask

    task automatic run_drain(int max_cyc);
        int k;
        k = 0;
        while ((sq.size() > 0 || mq.size() > 0 || phase != 0) && k < max_cyc) begin
            step();
            k++;
        end
        if (k >= max_cyc) begin
            n_chk++; n_fail++;
            $display("FAIL drain_timeout: still busy after %0d cycles, expected idle", max_cyc);
        end
        repeat (2) step();
    endtask

    initial begin
        cyc = 0; n_start = 0; n_deliv = 0; n_acc = 0; last_at = 0;
        first_acc = -1; first_start = -1; first_v = -1;
        model_reset();
        do_reset();

        // nominal frame
        valid_pct = 100; ready_pct = 100;
        add_frame(-1, 0, 0, 0, 0);
        run_drain(300);
        check("nom_starts", n_start, 1);
        check("nom_delivered", n_deliv, 16);
        check("nom_last_beat", last_at, 16);
        check("nom_frame_cnt", int'(fcnt_a[0]), 1);
        check("nom_err_geom", int'(err_a[0]), 0);
        check("nom_start_latency", first_start - first_acc, 2);
        check("nom_valid_latency", first_v - first_acc, 3);

        // backpressure
        ready_pct = 0; n_acc = 0; n_deliv = 0;
        add_frame(-1, 0, 0, 0, 0);
        repeat (20) step();
        check("bp_accepted", n_acc, 8);
        check("bp_level", int'(lvl_a[0]), 8);
        check("bp_q_ready", int'(rdy_a[0]), 0);
        ready_pct = 100;
        run_drain(300);
        check("bp_delivered", n_deliv, 16);
        check("bp_frame_cnt", int'(fcnt_a[0]), 2);

        // geometry error: line_last at col 2
        add_frame(2, 0, 0, 0, 0);
        run_drain(300);
        check("geom_err_sticky", int'(err_a[0]), 1);
        check("geom_frame_cnt", int'(fcnt_a[0]), 3);

        // width casts on held head entries
        ready_pct = 0;
        add_frame(-1, 1, 8'hFD, 8'h7F, 8'h18);
        repeat (12) step();
        check("cast_v", int'(v_a[0]), 1);
        check("cast12_m3", int'(pix12), 'hFFD);
        check("cast4_m3", int'(pix4), 'h0);
        check("cast8_m3", int'(pix8), 'hFD);
        ready_pct = 100; step(); ready_pct = 0; step();
        check("cast12_7f", int'(pix12), 'h07F);
        check("cast4_7f_sat", int'(pix4), 'h7);
        ready_pct = 100; step(); ready_pct = 0; step();
        check("cast12_18", int'(pix12), 'h018);
        check("cast4_18_round", int'(pix4), 'h2);
        ready_pct = 100;
        run_drain(300);

        // reset mid-frame
        n_acc = 0;
        add_frame(-1, 0, 0, 0, 0);
        for (int k = 0; k < 100 && n_acc < 5; k++) step();
        check("mid_accepts", n_acc, 5);
        do_reset();
        n_start = 0;
        add_frame(-1, 0, 0, 0, 0);
        run_drain(300);
        check("mid_starts", n_start, 1);
        check("mid_frame_cnt", int'(fcnt_a[0]), 1);

        // back-to-back frames
        n_start = 0;
        add_frame(-1, 0, 0, 0, 0);
        add_frame(-1, 0, 0, 0, 0);
        run_drain(400);
        check("b2b_starts", n_start, 2);
        check("b2b_frame_cnt", int'(fcnt_a[0]), 3);

        // randomised traffic with occasional geometry faults and resets
        for (int r = 0; r < 8; r++) begin
            int bad;
            valid_pct = int'($urandom_range(30, 100));
            ready_pct = int'($urandom_range(20, 100));
            bad = int'($urandom_range(0, 47));
            add_frame((bad < 16) ? bad : -1, 0, 0, 0, 0);
            if (r == 4) begin
                repeat (int'($urandom_range(3, 12))) step();
                do_reset();
            end else begin
                run_drain(2000);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
